// File: rtl/rf_sched_pkg.sv
// Shared types and defaults for the register-file read scheduler.
package rf_sched_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int RADR_W_DEF = 5;

  typedef enum logic [2:0] {
    IDLE,
    RS1,
    RS2,
    DONE,
    DBG,
    DBGCAP
  } state_t;

  // Which requester currently holds round-robin priority
  typedef enum logic {
    OWN_ID,
    OWN_DBG
  } owner_t;

endpackage

// File: rtl/rf_bypass_mux.sv
// Write-to-read forwarding select, instanced only when RF_READ_BYPASS_EN is defined.
module rf_bypass_mux
  import rf_sched_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int RADR_W = RADR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RADR_W-1:0] ram_radr,
  input  logic [RADR_W-1:0] cap_adr,
  input  logic              wb_wen,
  input  logic [RADR_W-1:0] wb_adr,
  input  logic [XLEN-1:0]   wb_wdata,
  input  logic [XLEN-1:0]   ram_rdata,
  output logic [XLEN-1:0]   rd_data
);

  logic            lat_hit;
  logic [XLEN-1:0] lat_data;
  logic            hit_now;

  // A write landing in the address cycle may not be visible in the RAM read yet
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_hit  <= 1'b0;
      lat_data <= '0;
    end else begin
      lat_hit  <= wb_wen && (wb_adr == ram_radr) && (ram_radr != '0);
      lat_data <= wb_wdata;
    end
  end

  always_comb begin
    hit_now = wb_wen && (wb_adr == cap_adr) && (cap_adr != '0);
    if (hit_now)
      rd_data = wb_wdata;
    else if (lat_hit)
      rd_data = lat_data;
    else
      rd_data = ram_rdata;
  end

endmodule

// File: rtl/rf_read_sched.sv
// Operand/debug read scheduler over a single-read-port register file RAM.
// Optional forwarding enabled by defining RF_READ_BYPASS_EN.
module rf_read_sched
  import rf_sched_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int RADR_W = RADR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_req,
  input  logic [RADR_W-1:0] id_rs1,
  input  logic [RADR_W-1:0] id_rs2,
  input  logic              stall,
  input  logic              dbg_req,
  input  logic [RADR_W-1:0] dbg_adr,
  output logic              dbg_ack,
  output logic [XLEN-1:0]   dbg_rdata,
  input  logic              wb_wen,
  input  logic [RADR_W-1:0] wb_adr,
  input  logic [XLEN-1:0]   wb_wdata,
  output logic [RADR_W-1:0] ram_radr,
  input  logic [XLEN-1:0]   ram_rdata,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic              id_done,
  output logic              id_busy
);

  state_t            state, state_nxt;
  owner_t            prio, prio_nxt;
  logic [RADR_W-1:0] adr_q;
  logic [XLEN-1:0]   rs1_q, rs2_q, dbg_q;
  logic [XLEN-1:0]   rd_val, cap_val;
  logic              id_ok;

`ifdef RF_READ_BYPASS_EN
  rf_bypass_mux #(
    .XLEN   (XLEN),
    .RADR_W (RADR_W)
  ) u_bypass (
    .clk       (clk),
    .rst       (rst),
    .ram_radr  (ram_radr),
    .cap_adr   (adr_q),
    .wb_wen    (wb_wen),
    .wb_adr    (wb_adr),
    .wb_wdata  (wb_wdata),
    .ram_rdata (ram_rdata),
    .rd_data   (rd_val)
  );
`else
  logic unused_wb;
  assign unused_wb = ^{wb_wen, wb_adr, wb_wdata};
  assign rd_val    = ram_rdata;
`endif

  assign cap_val = (adr_q == '0) ? '0 : rd_val;
  assign id_ok   = id_req && !stall;

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    ram_radr  = dbg_adr;
    unique case (state)
      IDLE: begin
        if (id_ok && (!dbg_req || prio == OWN_ID)) begin
          ram_radr  = id_rs1;
          state_nxt = RS1;
          prio_nxt  = OWN_DBG;
        end else if (dbg_req) begin
          state_nxt = DBG;
          prio_nxt  = OWN_ID;
        end
      end
      RS1: begin
        ram_radr  = id_rs1;
        state_nxt = stall ? IDLE : RS2;
      end
      RS2: begin
        ram_radr  = id_rs2;
        state_nxt = stall ? IDLE : DONE;
      end
      DONE:    state_nxt = IDLE;
      DBG:     state_nxt = DBGCAP;
      DBGCAP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM data lags its address by a cycle, so adr_q names what ram_rdata holds
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio  <= OWN_ID;
      adr_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      dbg_q <= '0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      adr_q <= ram_radr;
      if (state == RS2)    rs1_q <= cap_val;
      if (state == DONE)   rs2_q <= cap_val;
      if (state == DBGCAP) dbg_q <= cap_val;
    end
  end

  // Capture cycles present the fresh value directly; the register holds it after
  assign rs1_data  = (state == RS2)    ? cap_val : rs1_q;
  assign rs2_data  = (state == DONE)   ? cap_val : rs2_q;
  assign dbg_rdata = (state == DBGCAP) ? cap_val : dbg_q;
  assign id_done   = (state == DONE);
  assign dbg_ack   = (state == DBGCAP);
  assign id_busy   = (state == RS1) || (state == RS2) || (state == DONE);

endmodule

// File: doc/rf_read_sched.md
RF_READ_SCHED -- requirements
Module: rf_read_sched

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter RADR_W, default 5, register address width.
REQ-003 SHALL have ports: clk in 1 system clock; rst in 1 reset, synchronous, active-high.
REQ-004 SHALL have ports: id_req in 1 operand-read request, held until id_done; id_rs1 in RADR_W; id_rs2 in RADR_W; stall in 1 pipeline abort.
REQ-005 SHALL have ports: dbg_req in 1 monitor read request, held until dbg_ack; dbg_adr in RADR_W; dbg_ack out 1; dbg_rdata out XLEN.
REQ-006 SHALL have ports: wb_wen in 1; wb_adr in RADR_W; wb_wdata in XLEN (write-back, also drives RAM write port).
REQ-007 SHALL have ports: ram_radr out RADR_W; ram_rdata in XLEN (RAM read data valid one cycle after address).
REQ-008 SHALL have ports: rs1_data out XLEN; rs2_data out XLEN; id_done out 1 one-cycle pulse; id_busy out 1.

Function
REQ-009 SHALL implement states IDLE, RS1, RS2, DONE, DBG, DBGCAP.
REQ-010 IDLE: ram_radr = id_rs1 when id_req is granted, else dbg_adr.
REQ-011 RS1: ram_radr = id_rs1; next RS2 unless stall.
REQ-012 RS2: rs1_data captured from read result; ram_radr = id_rs2; next DONE unless stall.
REQ-013 DONE: rs2_data valid; id_done = 1 for exactly this cycle; next IDLE.
REQ-014 ID latency: id_req sampled in IDLE at cycle 0 -> id_done at cycle 3.
REQ-015 DBG: ram_radr = dbg_adr; next DBGCAP. DBGCAP: dbg_rdata loaded; dbg_ack = 1 one cycle; next IDLE.
REQ-016 Simultaneous id_req and dbg_req in IDLE: round-robin; the requester not granted last wins; after reset ID has priority.
REQ-017 stall in RS1 or RS2 -> IDLE next cycle; id_done not asserted; rs1_data may hold a partial update; id_req is re-arbitrated from IDLE.
REQ-018 stall in IDLE or DONE: no effect on DONE's id_done; IDLE does not grant ID while stall = 1; debug transactions ignore stall.
REQ-019 Read address 0 SHALL return 0 regardless of RAM data or bypass.
REQ-020 id_busy = 1 in RS1, RS2, DONE.
REQ-021 Captured outputs SHALL hold value until the next capture.

Reset
REQ-022 On rst at a clk edge: state IDLE; rs1_data, rs2_data, dbg_rdata = 0; id_done, dbg_ack, id_busy = 0; round-robin pointer = ID.
REQ-023 rst mid-transaction SHALL abandon it with no done/ack pulse.

Configuration
REQ-024 Macro RF_READ_BYPASS_EN SHALL enable write-to-read forwarding.
REQ-025 With RF_READ_BYPASS_EN, at a capture cycle the result SHALL be chosen in this order:
- wb_wdata, if wb_wen and wb_adr equal the captured address;
- else the write data latched in the address cycle, if wb_wen and wb_adr matched ram_radr then;
- else ram_radr's RAM data, i.e. ram_rdata.
Address 0 is never forwarded.
REQ-026 Without RF_READ_BYPASS_EN, ram_rdata SHALL be captured unmodified; hazards are resolved by the pipeline.

Structure
REQ-027 Shared package rf_sched_pkg SHALL hold the state enum, XLEN and RADR_W defaults, and the grant-owner type.
REQ-028 Forwarding select logic SHALL be sub-module rf_bypass_mux, instanced once and compiled out without the macro.

Verification
REQ-029 id_req with rs1 = 3 (RAM 0x11), rs2 = 7 (RAM 0x22) -> ram_radr 3, 3, 7; id_done at cycle 3; rs1_data = 0x11; rs2_data = 0x22.
REQ-030 id_req and dbg_req (adr 5, RAM 0x55) both high from reset -> ID serviced first; then dbg_ack with dbg_rdata = 0x55; next conflict grants ID.
REQ-031 stall during RS2 -> no id_done; IDLE next cycle; a held id_req completes on retry with correct data.
REQ-032 rs1 = 0, RAM[0] forced 0xFFFF_FFFF -> rs1_data = 0.
REQ-033 With bypass, wb_wen writing x7 = 0xABCD in the rs2 address cycle (RAM stale 0x22) -> rs2_data = 0xABCD; without the macro -> 0x22.
REQ-034 rst asserted in RS2 -> IDLE; all outputs 0; no pulses.
